// File: rtl/mips_cache_wbuf_param.sv
// ---------------------------------------------------------------------------
// mips_cache_wbuf_param
//   In-order write buffer between the data cache and the Avalon-MM write
//   master. Cache write-throughs are queued in a circular array and drained
//   one entry per accepted bus transfer. A combinational lookup port lets a
//   read miss see pending stores (byte-merged, youngest entry wins per lane).
//
//   Optional build macro: MIPS_WBUF_COALESCE_EN
//     When defined, a push that hits the youngest entry's word merges into
//     that entry instead of allocating a new one.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_*              write request from the cache (valid/ready handshake)
//   active            drain permission; low pauses starting new bus writes
//   waitrequest       Avalon waitrequest
//   avm_*             Avalon write master, driven from the head entry
//   lk_addr/lk_*      combinational lookup of pending stores
//   count/full/empty  occupancy
// ---------------------------------------------------------------------------
module mips_cache_wbuf_param #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [DATA_W/8-1:0]     in_byteenable,
    output logic                    in_ready,
    input  logic                    active,
    input  logic                    waitrequest,
    output logic [ADDR_W-1:0]       avm_address,
    output logic [DATA_W-1:0]       avm_writedata,
    output logic [DATA_W/8-1:0]     avm_byteenable,
    output logic                    avm_write,
    input  logic [ADDR_W-1:0]       lk_addr,
    output logic                    lk_hit,
    output logic [DATA_W-1:0]       lk_data,
    output logic [DATA_W/8-1:0]     lk_byteenable,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    full,
    output logic                    empty
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_PAUSE} state_t;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [BE_W-1:0]   r_be   [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_lock;

    state_t            w_state;
    logic              w_lock_nxt;
    logic              w_pop, w_alloc, w_coal;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic word_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:OFF_W] == b[ADDR_W-1:OFF_W];
    endfunction

    // byte offset of the lookup address never takes part in a match
    generate
        if (OFF_W > 0) begin : g_lk_off
            logic w_unused_lk_off;
            assign w_unused_lk_off = ^lk_addr[OFF_W-1:0];
        end
    endgenerate

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));

    // Head entry is shown even while paused; zero when nothing is queued.
    assign avm_address    = empty ? '0 : r_addr[r_head];
    assign avm_writedata  = empty ? '0 : r_data[r_head];
    assign avm_byteenable = empty ? '0 : r_be[r_head];

    // Drain control. The lock keeps a stalled transfer alive after `active`
    // drops so an Avalon write is never withdrawn mid-flight.
    always_comb begin
        w_state    = S_IDLE;
        w_lock_nxt = r_lock;
        if (!empty)
            w_state = (active || r_lock) ? S_DRAIN : S_PAUSE;
        avm_write = (w_state == S_DRAIN);
        if (avm_write && !waitrequest)
            w_lock_nxt = 1'b0;
        else if (avm_write && waitrequest)
            w_lock_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_lock <= 1'b0;
        else     r_lock <= w_lock_nxt;
    end

    assign w_pop = avm_write && !waitrequest;

`ifdef MIPS_WBUF_COALESCE_EN
    logic [PTR_W-1:0] w_young;
    assign w_young = (r_tail == '0) ? PTR_W'(DEPTH - 1) : r_tail - PTR_W'(1);
    // A head entry already on the bus must not change under the master.
    assign w_coal  = !empty && r_vld[w_young] && word_eq(r_addr[w_young], in_addr)
                     && !((w_young == r_head) && avm_write);
`else
    assign w_coal  = 1'b0;
`endif

    assign in_ready = !full || w_coal;
    assign w_alloc  = in_valid && !w_coal && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= ptr_inc(r_head);
            end
            if (w_alloc) begin
                r_addr[r_tail] <= in_addr;
                r_data[r_tail] <= in_data;
                r_be[r_tail]   <= in_byteenable;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= ptr_inc(r_tail);
            end
`ifdef MIPS_WBUF_COALESCE_EN
            if (in_valid && w_coal) begin
                for (int b = 0; b < BE_W; b++)
                    if (in_byteenable[b])
                        r_data[w_young][8*b +: 8] <= in_data[8*b +: 8];
                r_be[w_young] <= r_be[w_young] | in_byteenable;
            end
`endif
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier lanes.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx           = '0;
        lk_hit        = 1'b0;
        lk_data       = '0;
        lk_byteenable = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PTR_W'(k);
            if (r_vld[idx] && word_eq(r_addr[idx], lk_addr)) begin
                lk_hit        = 1'b1;
                lk_byteenable = lk_byteenable | r_be[idx];
                for (int b = 0; b < BE_W; b++)
                    if (r_be[idx][b])
                        lk_data[8*b +: 8] = r_data[idx][8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_cache_wbuf_param.sv
// ---------------------------------------------------------------------------
// Testbench for mips_cache_wbuf_param (default parameters, DEPTH = 8).
// The reference is a queue of pending stores plus an in-flight flag; every
// cycle all outputs are compared against it, then it is advanced with the
// same inputs the DUT sees at the clock edge.
// ---------------------------------------------------------------------------
module tb_mips_cache_wbuf_param;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_byteenable;
    logic        in_ready;
    logic        active;
    logic        waitrequest;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic [31:0] lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [3:0]  lk_byteenable;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    always #5 clk = ~clk;

    mips_cache_wbuf_param dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_byteenable(in_byteenable), .in_ready(in_ready),
        .active(active), .waitrequest(waitrequest),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_write(avm_write),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .lk_byteenable(lk_byteenable),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    bit   inflight;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance.
    task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit act, input bit wr,
                       input logic [31:0] lka);
        int   n;
        bit   e_wr, e_rdy, merge, pop, acc;
        bit   e_hit;
        logic [31:0] e_lkd;
        logic [3:0]  e_lkbe;
        ent_t e;
        in_valid = v; in_addr = a; in_data = d; in_byteenable = be;
        active = act; waitrequest = wr; lk_addr = lka;
        #1;
        n     = q.size();
        e_wr  = (n > 0) && (act || inflight);
        merge = 1'b0;
`ifdef MIPS_WBUF_COALESCE_EN
        merge = (n > 0) && (q[n-1].a[31:2] == a[31:2]) && !(n == 1 && e_wr);
`endif
        e_rdy  = (n < DEPTH) || merge;
        e_hit  = 1'b0;
        e_lkd  = '0;
        e_lkbe = '0;
        foreach (q[i]) begin
            if (q[i].a[31:2] == lka[31:2]) begin
                e_hit  = 1'b1;
                e_lkbe = e_lkbe | q[i].be;
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b]) e_lkd[8*b +: 8] = q[i].d[8*b +: 8];
            end
        end
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("avm_write", 32'(avm_write), 32'(e_wr));
        chk("avm_address", avm_address, (n > 0) ? q[0].a : 32'h0);
        chk("avm_writedata", avm_writedata, (n > 0) ? q[0].d : 32'h0);
        chk("avm_byteenable", 32'(avm_byteenable), (n > 0) ? 32'(q[0].be) : 32'h0);
        chk("lk_hit", 32'(lk_hit), 32'(e_hit));
        chk("lk_data", lk_data, e_lkd);
        chk("lk_byteenable", 32'(lk_byteenable), 32'(e_lkbe));
        pop = e_wr && !wr;
        acc = v && e_rdy;
        if (acc && merge) begin
            e = q[n-1];
            for (int b = 0; b < 4; b++)
                if (be[b]) e.d[8*b +: 8] = d[8*b +: 8];
            e.be = e.be | be;
            q[n-1] = e;
        end
        if (pop) void'(q.pop_front());
        if (acc && !merge) begin
            e.a = a; e.d = d; e.be = be;
            q.push_back(e);
        end
        if (pop) inflight = 1'b0;
        else if (e_wr && wr) inflight = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++)
            cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        chk("drain_empty", 32'(empty), 32'h1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_byteenable = '0; active = 1'b0; waitrequest = 1'b0; lk_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        inflight = 1'b0;

        // Reset state
        chk("rst_avm_write", 32'(avm_write), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_lk_hit", 32'(lk_hit), 32'h0);
        chk("rst_avm_address", avm_address, 32'h0);

        // Single push drains the next cycle
        cyc(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h100);
        chk("t1_avm_write", 32'(avm_write), 32'h1);
        chk("t1_avm_address", avm_address, 32'h100);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        chk("t1_empty", 32'(empty), 32'h1);
        chk("t1_count", 32'(count), 32'h0);

        // Fill to full while paused, ignored 9th push, ordered drain with wrap
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h1000 + 32'(i) * 4, $urandom, 4'hF, 1'b0, 1'b0, 32'h0);
        chk("t2_full", 32'(full), 32'h1);
        chk("t2_in_ready", 32'(in_ready), 32'h0);
        cyc(1'b1, 32'h9990, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h9990);
        chk("t2_ignored_lk", 32'(lk_hit), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", avm_address, 32'h1000 + 32'(i) * 4);
            cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        end
        chk("t2_empty", 32'(empty), 32'h1);

        // Stalled transfer survives active dropping
        cyc(1'b1, 32'h20, 32'hAAAA0001, 4'hF, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h24, 32'hAAAA0002, 4'hF, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
        chk("t3_hold_write", 32'(avm_write), 32'h1);
        chk("t3_hold_addr", avm_address, 32'h20);
        chk("t3_hold_data", avm_writedata, 32'hAAAA0001);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        chk("t3_paused", 32'(avm_write), 32'h0);
        chk("t3_count", 32'(count), 32'h1);
        drain();

        // Byte-merged lookup, youngest wins
        cyc(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h202, 32'h0000AA00, 4'h2, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h200);
        chk("t4_lk_hit", 32'(lk_hit), 32'h1);
        chk("t4_lk_data", lk_data, 32'h1122AA44);
        chk("t4_lk_be", 32'(lk_byteenable), 32'hF);
        drain();

        // Simultaneous push and pop; push at full ignored even with a pop
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h2000 + 32'(i) * 4, $urandom, 4'hF, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h2100, 32'h55, 4'hF, 1'b1, 1'b0, 32'h0);
        chk("t5_pushpop_count", 32'(count), 32'h3);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h2200 + 32'(i) * 4, $urandom, 4'hF, 1'b0, 1'b0, 32'h0);
        chk("t5_full", 32'(full), 32'h1);
        cyc(1'b1, 32'h2300, 32'h66, 4'hF, 1'b1, 1'b0, 32'h0);
        chk("t5_full_pop_count", 32'(count), 32'h7);
        drain();

`ifdef MIPS_WBUF_COALESCE_EN
        cyc(1'b1, 32'h300, 32'h000000FF, 4'h1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h300, 32'h0000FF00, 4'h2, 1'b0, 1'b0, 32'h0);
        chk("t6_count", 32'(count), 32'h1);
        chk("t6_data", avm_writedata, 32'h0000FFFF);
        chk("t6_be", 32'(avm_byteenable), 32'h3);
        drain();
`endif

        // Randomized traffic on a few words to exercise hits and wrap
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 2) == 0,
                32'h400 + 32'($urandom % 4) * 4 + 32'($urandom % 4),
                $urandom, 4'($urandom),
                ($urandom % 10) < 7, ($urandom % 10) < 3,
                32'h400 + 32'($urandom % 5) * 4 + 32'($urandom % 4));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cache_wbuf_param.md
Name: mips_cache_wbuf_param

Overview:
- Parametrised, depth-configurable write buffer between the data cache and the Avalon-MM write master.
- Accepts cache write-throughs, queues them in order and drains them to memory one per accepted bus transfer.
- Provides a combinational lookup port so a read miss can see pending stores (byte-merged, youngest wins) before memory is updated.
- Adds occupancy count, transaction lock under `active` gating, and optional store coalescing.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits (multiple of 8); BE_W = DATA_W/8.
- DEPTH_LOG2, 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2, minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  write request from cache
- in_addr  in  ADDR_W  byte address of write
- in_data  in  DATA_W  write data
- in_byteenable  in  BE_W  byte lanes
- in_ready  out  1  request accepted this cycle when in_valid & in_ready
- active  in  1  drain permission; low pauses new bus writes (read-miss hijack)
- waitrequest  in  1  Avalon waitrequest
- avm_address  out  ADDR_W  head entry address
- avm_writedata  out  DATA_W  head entry data
- avm_byteenable  out  BE_W  head entry byte lanes
- avm_write  out  1  Avalon write strobe
- lk_addr  in  ADDR_W  lookup address
- lk_hit  out  1  any valid entry matches lk_addr word
- lk_data  out  DATA_W  merged matching data, youngest entry per byte
- lk_byteenable  out  BE_W  OR of matching entries' byte lanes
- count  out  DEPTH_LOG2+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: circular array; head (oldest) pointer, tail (next free) pointer, count register. Pointers wrap modulo DEPTH.
- Reset: head = tail = count = 0, lock = 0, all entries invalid.
  - Outputs after reset: avm_write = 0, in_ready = 1, empty = 1, full = 0, lk_hit = 0, lk_byteenable = 0, lk_data = 0.
  - avm_address, avm_writedata and avm_byteenable read 0.
- Push: in_ready = !full (combinational). On in_valid & in_ready, write entry at tail and advance tail.
  - A push while full is ignored, even if a pop occurs in the same cycle.
- Latency: a pushed entry is visible on the avm_* outputs and the lookup port the cycle after the push. No same-cycle bypass.
- Drain FSM:
  - States: S_IDLE (empty), S_DRAIN (non-empty & (active | lock)), S_PAUSE (non-empty & !active & !lock). The state is derivable; exposing it is not required.
  - avm_write = !empty & (active | lock).
  - avm_* address, data and byteenable are driven combinationally from the head entry and are held stable while waitrequest is high.
  - lock sets when avm_write & waitrequest. It clears when the transfer is accepted (avm_write & !waitrequest).
  - Dropping `active` never aborts an in-flight transfer. `active` only prevents starting a new one.
- Pop: on avm_write & !waitrequest, invalidate head and advance head.
- Count on simultaneous push and pop: count is unchanged; head and tail both advance.
- Lookup: a word match compares addr[ADDR_W-1:log2(BE_W)] and ignores byte offset.
  - Per byte lane, lk_data takes the lane from the youngest valid matching entry whose byteenable covers that lane. Lanes with no such entry read 0.
  - The entry being popped in the current cycle still participates in the lookup.
- Wrap-around: full at tail == head with count == DEPTH. Empty is decided by count, never by pointer equality alone.
- Reset mid-transfer: state is cleared immediately; avm_write drops the next cycle and pending entries are lost. This is the owner's responsibility.

Optional Feature:
- Macro: MIPS_WBUF_COALESCE_EN.
- Defined: a push whose word address matches the youngest valid entry (tail-1) merges into that entry instead of allocating.
  - Merged data: bytes with in_byteenable set are overwritten; byteenable is ORed.
  - No allocation occurs and count is unchanged.
  - Merging is allowed when full (in_ready = !full | coalesce_match).
  - Merging is forbidden if that entry is the head and avm_write is asserted; in that case the push allocates normally.
- Undefined: every accepted push allocates a new entry; in_ready = !full.

Test Plan:
- Reset, then push A = 0x100/0xDEADBEEF/4'hF with waitrequest = 0, active = 1 -> next cycle avm_write = 1, avm_address = 0x100; the cycle after, empty = 1 and count = 0.
- Push 8 entries with active = 0 -> full = 1, in_ready = 0; a 9th push is ignored; raise active -> 8 writes drain in push order, with tail and head wrapping to 0.
- Hold waitrequest = 1 for 3 cycles with active = 1, then drop active -> avm_write stays 1 with stable address/data until waitrequest = 0; then avm_write = 0 while active = 0.
- Push 0x200/0x11223344/4'hF, then 0x202/0x0000AA00/4'h2 (no coalesce) -> lk_addr = 0x200 gives lk_hit = 1, lk_data = 0x1122AA44, lk_byteenable = 4'hF.
- Simultaneous push and pop at count = 3 -> count stays 3; at full with a pop, the push is ignored and count becomes 7.
- With MIPS_WBUF_COALESCE_EN and active = 0: push 0x300/0x000000FF/4'h1, then 0x300/0x0000FF00/4'h2 -> count = 1, head entry data 0x0000FFFF, byteenable 4'h3.
